keccak_msg_tx: RTL
==================

KECCAK_MSG_TX -- requirements
Module: keccak_msg_tx

Interface
REQ-001 The parameter list SHALL be: WORD_WIDTH, default 32, upstream word width.
REQ-002 The parameter list SHALL include: OUT_DATA_WIDTH, default 128, downstream beat width; fixed ratio of 4 words per beat.
REQ-003 Port: i_clk  input  1  single clock, all state on rising edge.
REQ-004 Port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: i_wvalid  input  1  upstream word valid.
REQ-006 Port: o_wready  output  1  block accepts word this cycle.
REQ-007 Port: i_wdata  input  WORD_WIDTH  upstream message word.
REQ-008 Port: i_wlast  input  1  word is final word of message.
REQ-009 Port: i_ready  input  1  hash core ready, driven by core o_ready.
REQ-010 Port: o_valid  output  1  beat valid to core i_valid.
REQ-011 Port: o_last  output  1  beat is last of message, to core i_last.
REQ-012 Port: o_data  output  OUT_DATA_WIDTH  beat to core i_data_a.
REQ-013 Port: o_msg_cnt  output  8  completed messages sent, wraps 255->0.

Function
REQ-014 Word transfer SHALL occur on a rising edge with i_wvalid=1 and o_wready=1.
REQ-015 Beat transfer SHALL occur on a rising edge with o_valid=1 and i_ready=1.
REQ-016 Word k of a beat (k=0..3) SHALL be packed into o_data[32k+31:32k], so word0 occupies the LSBs.
REQ-017 Packing register plus 2-bit fill count SHALL accumulate words; a beat completes on the 4th word or on any word with i_wlast=1.
REQ-018 An incomplete final beat SHALL zero-fill the unused upper words; o_last=1 on that beat.
REQ-019 i_wlast on word 3 SHALL produce exactly one beat with o_last=1, with no extra padding beat.
REQ-020 A completed beat SHALL move to the output register when the output register is empty or is being transferred in that cycle: zero-bubble handoff.
REQ-021 o_valid, o_last and o_data SHALL hold stable while o_valid=1 and i_ready=0.
REQ-022 o_wready SHALL be 0 only when the packing register holds a completed beat that cannot move this cycle; otherwise 1.
REQ-023 o_wready SHALL be combinational from i_ready and internal state, with no path from i_wvalid.
REQ-024 A beat with o_last=1 SHALL increment o_msg_cnt by 1 on its transfer edge.
REQ-025 The fill count SHALL reset to 0 after a completed beat; the next word starts a new beat. A new message MAY begin packing while the previous last beat waits in the output register.
REQ-026 Sustained throughput SHALL be 4 words per beat with no idle cycles when i_wvalid=1 and i_ready=1 continuously.
REQ-027 Empty messages are not supported: i_wlast is only meaningful with i_wvalid=1, and i_wlast with i_wvalid=0 SHALL be ignored.

Reset
REQ-028 While i_rst_n=0: o_valid=0, o_last=0, o_data=0, o_msg_cnt=0, fill count=0, packing register=0.
REQ-029 o_wready SHALL be 0 while i_rst_n=0 and 1 from the first edge after release.
REQ-030 Reset asserted mid-message SHALL discard all partial and pending beats; no beat is emitted after release until new words arrive.

Verification
REQ-031 Four words 0x11111111,0x22222222,0x33333333,0x44444444 (last on 4th), i_ready=1 -> one beat o_data=0x44444444_33333333_22222222_11111111, o_last=1, o_msg_cnt=1.
REQ-032 Six words 1..6, last on 6th -> beat1 0x4_3_2_1 (as 32-bit words) o_last=0; beat2 0x0_0_6_5 o_last=1; o_msg_cnt=1.
REQ-033 i_ready=0 for 10 cycles with 12 words offered -> o_valid held with stable data; o_wready drops after 8 words accepted; all 3 beats delivered in order once i_ready=1.
REQ-034 71 beats back-to-back, i_ready=1, continuous i_wvalid -> 284 words accepted in 284 cycles, no bubbles.
REQ-035 i_rst_n pulsed low after word 2 of a message -> outputs zero immediately; next 4-word message yields a correct single beat with o_msg_cnt=1.
REQ-036 256 single-word messages -> o_msg_cnt wraps to 0; each beat has only its low word nonzero and o_last=1.

Source files
------------

// File: rtl/keccak_msg_tx.sv
// Packs upstream message words into 4-word beats for the hash core, with a
// packing stage and an output register so a full beat never costs a bubble.
module keccak_msg_tx #(
    parameter int WORD_WIDTH     = 32,
    parameter int OUT_DATA_WIDTH = 128
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_wvalid,
    output logic                      o_wready,
    input  logic [WORD_WIDTH-1:0]     i_wdata,
    input  logic                      i_wlast,
    input  logic                      i_ready,
    output logic                      o_valid,
    output logic                      o_last,
    output logic [OUT_DATA_WIDTH-1:0] o_data,
    output logic [7:0]                o_msg_cnt
);

    localparam int WordsPerBeat = 4;

    logic [OUT_DATA_WIDTH-1:0] pack_q, pack_d;
    logic [1:0]                fill_q, fill_d;
    logic                      pack_full_q, pack_full_d;
    logic                      pack_last_q, pack_last_d;
    logic [OUT_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic [7:0]                msg_cnt_q, msg_cnt_d;
    logic                      live_q;

    logic                      out_free;
    logic                      pack_move;
    logic                      wready;
    logic                      accept;
    logic                      complete;
    logic                      direct;
    logic [OUT_DATA_WIDTH-1:0] base;
    logic [OUT_DATA_WIDTH-1:0] merged;

    always_comb begin
        out_free  = !out_valid_q || i_ready;
        pack_move = pack_full_q && out_free;
        // Stall only when a finished beat is parked and the output cannot take it.
        wready    = live_q && !(pack_full_q && !out_free);
        accept    = i_wvalid && wready;

        // A parked beat is leaving this cycle, so a new word starts from zero.
        base = pack_full_q ? '0 : pack_q;
        merged = base;
        for (int k = 0; k < WordsPerBeat; k++) begin
            if (fill_q == 2'(k)) begin
                merged[k*WORD_WIDTH +: WORD_WIDTH] = i_wdata;
            end
        end

        complete = accept && ((fill_q == 2'd3) || i_wlast);
        direct   = complete && out_free && !pack_full_q;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        msg_cnt_d   = msg_cnt_q;

        if (out_valid_q && i_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (out_last_q) begin
                msg_cnt_d = msg_cnt_q + 8'd1;
            end
        end

        if (pack_move) begin
            out_data_d  = pack_q;
            out_last_d  = pack_last_q;
            out_valid_d = 1'b1;
        end else if (direct) begin
            out_data_d  = merged;
            out_last_d  = i_wlast;
            out_valid_d = 1'b1;
        end
    end

    always_comb begin
        pack_d      = pack_q;
        fill_d      = fill_q;
        pack_full_d = pack_full_q;
        pack_last_d = pack_last_q;

        if (accept) begin
            if (complete) begin
                fill_d = 2'd0;
                if (direct) begin
                    pack_d      = '0;
                    pack_full_d = 1'b0;
                    pack_last_d = 1'b0;
                end else begin
                    pack_d      = merged;
                    pack_full_d = 1'b1;
                    pack_last_d = i_wlast;
                end
            end else begin
                pack_d      = merged;
                fill_d      = fill_q + 2'd1;
                pack_full_d = 1'b0;
                pack_last_d = 1'b0;
            end
        end else if (pack_move) begin
            pack_d      = '0;
            pack_full_d = 1'b0;
            pack_last_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pack_q      <= '0;
            fill_q      <= 2'd0;
            pack_full_q <= 1'b0;
            pack_last_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            msg_cnt_q   <= 8'd0;
            live_q      <= 1'b0;
        end else begin
            pack_q      <= pack_d;
            fill_q      <= fill_d;
            pack_full_q <= pack_full_d;
            pack_last_q <= pack_last_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            msg_cnt_q   <= msg_cnt_d;
            live_q      <= 1'b1;
        end
    end

    assign o_wready  = wready;
    assign o_valid   = out_valid_q;
    assign o_last    = out_last_q;
    assign o_data    = out_data_q;
    assign o_msg_cnt = msg_cnt_q;

endmodule
